// File: rtl/riscvibe_pkg.sv
// Shared types and defaults for the RV32I core's debug halt controller.
package riscvibe_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        DRAIN  = 3'd1,
        HALTED = 3'd2,
        ACCESS = 3'd3,
        RESUME = 3'd4
    } dbg_state_t;

    localparam int DBG_DRAIN_TIMEOUT = 16;

    // Every state except RUN keeps fetch frozen and ID bubbling.
    function automatic logic pipe_frozen(input dbg_state_t s);
        return s != RUN;
    endfunction

endpackage

// File: rtl/dbg_halt_ctrl.sv
// Debug halt controller: drains the pipeline on request, then lends the
// register file's rs1 read port and write port to the debugger one access at a time.
module dbg_halt_ctrl
    import riscvibe_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = DBG_DRAIN_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_halt_req,
    output logic        dbg_halted,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        drain_err,
    output logic        fetch_stall,
    output logic        id_bubble,
    input  logic        ex_valid,
    input  logic        mem_valid,
    input  logic        wb_valid,
    input  logic [4:0]  id_rs1_addr,
    output logic [4:0]  rf_rs1_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_rd_data,
    input  logic        wb_reg_write,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_rd_data,
    output logic        rf_reg_write
);

    localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    dbg_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain_err_q, drain_err_d;
    logic [4:0]        lat_addr_q, lat_addr_d;
    logic              lat_we_q, lat_we_d;
    logic [31:0]       lat_wdata_q, lat_wdata_d;
    logic [31:0]       dbg_rdata_q, dbg_rdata_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic              fetch_stall_q, fetch_stall_d;
    logic              id_bubble_q, id_bubble_d;
    logic              dbg_halted_q, dbg_halted_d;
    logic              dbg_gnt_q, dbg_gnt_d;
    logic              pipe_busy;

    assign pipe_busy = ex_valid | mem_valid | wb_valid;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drain_err_d  = drain_err_q;
        lat_addr_d   = lat_addr_q;
        lat_we_d     = lat_we_q;
        lat_wdata_d  = lat_wdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_rvalid_d = 1'b0;
        case (state_q)
            RUN: begin
                drain_err_d = 1'b0;
                if (dbg_halt_req) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            // A dropped halt request is deliberately ignored until the pipe is empty.
            DRAIN: begin
                if (!pipe_busy) begin
                    state_d = HALTED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HALTED;
                    drain_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HALTED: begin
                if (dbg_req) begin
                    state_d     = ACCESS;
                    lat_addr_d  = dbg_addr;
                    lat_we_d    = dbg_we;
                    lat_wdata_d = dbg_wdata;
                end else if (!dbg_halt_req) begin
                    state_d = RESUME;
                end
            end
            ACCESS: begin
                state_d = HALTED;
                if (!lat_we_q) begin
                    dbg_rdata_d  = rf_rs1_data;
                    dbg_rvalid_d = 1'b1;
                end
            end
            RESUME: begin
                state_d     = RUN;
                drain_err_d = 1'b0;
            end
            default: state_d = RUN;
        endcase

        // Decoded from the next state so the flops mirror the registered state.
        fetch_stall_d = pipe_frozen(state_d);
        id_bubble_d   = pipe_frozen(state_d);
        dbg_halted_d  = (state_d == HALTED);
        dbg_gnt_d     = (state_d == ACCESS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            drain_err_q   <= 1'b0;
            lat_addr_q    <= '0;
            lat_we_q      <= 1'b0;
            lat_wdata_q   <= '0;
            dbg_rdata_q   <= '0;
            dbg_rvalid_q  <= 1'b0;
            fetch_stall_q <= 1'b0;
            id_bubble_q   <= 1'b0;
            dbg_halted_q  <= 1'b0;
            dbg_gnt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            drain_err_q   <= drain_err_d;
            lat_addr_q    <= lat_addr_d;
            lat_we_q      <= lat_we_d;
            lat_wdata_q   <= lat_wdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            fetch_stall_q <= fetch_stall_d;
            id_bubble_q   <= id_bubble_d;
            dbg_halted_q  <= dbg_halted_d;
            dbg_gnt_q     <= dbg_gnt_d;
        end
    end

    // Register-file port muxes; the WB write port only reaches the file while instructions can retire.
    always_comb begin
        rf_rs1_addr  = id_rs1_addr;
        rf_rd_addr   = wb_rd_addr;
        rf_rd_data   = wb_rd_data;
        rf_reg_write = 1'b0;
        case (state_q)
            RUN, DRAIN: rf_reg_write = wb_reg_write;
            ACCESS: begin
                if (lat_we_q) begin
                    rf_rd_addr   = lat_addr_q;
                    rf_rd_data   = lat_wdata_q;
                    rf_reg_write = (lat_addr_q != 5'd0);
                end else begin
                    rf_rs1_addr = lat_addr_q;
                end
            end
            default: rf_reg_write = 1'b0;
        endcase
    end

    assign dbg_halted  = dbg_halted_q;
    assign dbg_gnt     = dbg_gnt_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign drain_err   = drain_err_q;
    assign fetch_stall = fetch_stall_q;
    assign id_bubble   = id_bubble_q;

endmodule

// File: doc/dbg_halt_ctrl.md
# dbg_halt_ctrl

Debug halt controller and register-file port arbiter for the 5-stage RV32I core. On a debug halt request it freezes fetch, bubbles decode, waits for EX/MEM/WB to drain, then hands the register file's rs1 read port and write port to a debug requester one access at a time. It sits beside the ID stage: it muxes the WB write port and the ID rs1 read address into the register file, and drives the stall/bubble controls used by IF and ID.

## Interface
Parameters:
- DRAIN_TIMEOUT, 16: cycles allowed in DRAIN before forced halt with error flag.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- dbg_halt_req  in  1  level; high = halt core, low = resume.
- dbg_halted  out  1  core halted, debug accesses accepted.
- dbg_req  in  1  access request, only honoured while halted.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  5  register index.
- dbg_wdata  in  32  write data.
- dbg_gnt  out  1  one-cycle pulse: access performed this cycle.
- dbg_rvalid  out  1  one-cycle pulse: dbg_rdata valid (reads only).
- dbg_rdata  out  32  read data, held until next read.
- drain_err  out  1  sticky: drain timed out.
- fetch_stall  out  1  freeze PC and IF/ID register.
- id_bubble  out  1  ID stage emits bubble (drives ID stall).
- ex_valid, mem_valid, wb_valid  in  1 each  stage holds a live instruction.
- id_rs1_addr  in  5  ID's rs1 read address.
- rf_rs1_addr  out  5  muxed rs1 address to register file.
- rf_rs1_data  in  32  register file rs1 read data.
- wb_rd_addr, wb_rd_data, wb_reg_write  in  5/32/1  WB write request.
- rf_rd_addr, rf_rd_data, rf_reg_write  out  5/32/1  muxed register file write port.

## Operation
- FSM states: RUN, DRAIN, HALTED, ACCESS, RESUME.
- RUN: pass-through (rf_* = wb_*, rf_rs1_addr = id_rs1_addr); fetch_stall = id_bubble = 0. dbg_halt_req=1 → DRAIN; clear drain counter.
- DRAIN: fetch_stall = id_bubble = 1; WB write port still passed through (draining instructions must retire). If ex_valid|mem_valid|wb_valid == 0 → HALTED. Else counter increments; counter == DRAIN_TIMEOUT-1 → HALTED and set drain_err. dbg_halt_req dropping in DRAIN is ignored until HALTED.
- HALTED: dbg_halted = 1, stalls held. dbg_req=1 → ACCESS (dbg_addr/we/wdata latched). Else dbg_halt_req=0 → RESUME. dbg_req takes priority over resume.
- ACCESS (one cycle): dbg_gnt = 1. Write: rf_rd_addr = latched addr, rf_rd_data = latched wdata, rf_reg_write = (addr != 0). Read: rf_rs1_addr = latched addr; rf_rs1_data captured into dbg_rdata at clock edge. → HALTED. dbg_rvalid = 1 the cycle after a read ACCESS.
- RESUME (one cycle): fetch_stall = 1, id_bubble = 1, pass-through restored so ID re-reads updated registers; → RUN. drain_err clears on entering RUN.
- WB writes outside RUN/DRAIN are impossible (pipeline empty); rf_reg_write = 0 in HALTED/RESUME.

## Timing
- Reset: state RUN; all outputs 0 except pass-through muxes; dbg_rdata = 0; drain_err = 0; counter = 0.
- fetch_stall, id_bubble, dbg_halted, dbg_gnt decoded from registered state (no combinational path from dbg_halt_req).
- Halt latency: req sampled at edge N → DRAIN from N+1; with pipeline full, EX/MEM/WB empty after 3 DRAIN cycles → HALTED at N+4.
- Access: dbg_req sampled in HALTED at edge N → ACCESS (gnt) cycle N+1 → rvalid cycle N+2 → next request acceptable at edge N+2. One access per 2 cycles.
- Resume: dbg_halt_req low sampled at edge N in HALTED → RESUME N+1 → RUN N+2.
- Reset asserted mid-ACCESS: write aborted if edge not yet reached; state RUN immediately.

## Structure
- riscvibe_pkg: dbg_state_t enum (RUN, DRAIN, HALTED, ACCESS, RESUME) and DBG_DRAIN_TIMEOUT default constant.
- Single module; FSM, counter and port muxes are small enough that no sub-module is warranted.

## Test plan
- Idle core, halt_req=1 at cycle 0, all valids 0 → DRAIN cycle 1, HALTED cycle 2, drain_err 0.
- Full pipeline (valids drop at cycles 2,3,4), WB writes x5=0x1234 during DRAIN → rf_reg_write passes through; HALTED after valids clear.
- Halted, write x7=0xDEADBEEF then read x7 → gnt pulses, rf write in ACCESS, dbg_rvalid with dbg_rdata=0xDEADBEEF two cycles after request.
- Write x0=0xFFFFFFFF then read x0 → rf_reg_write=0, dbg_rdata=0.
- ex_valid stuck 1 → HALTED after 16 DRAIN cycles, drain_err=1; drop halt_req → RESUME, RUN, drain_err=0.
- dbg_req and halt_req drop same cycle in HALTED → ACCESS first, then RESUME; rst pulse in ACCESS → outputs to reset values immediately.
